// File: rtl/fwd_pkg.sv
// Shared definitions for the operand/forwarding mux: default sizes, the
// forwarding select encodings used by the hazard unit, and a log2 helper.
package fwd_pkg;

  localparam int FWD_WIDTH  = 32;
  localparam int FWD_NUM_IN = 3;
  localparam int FWD_SEL_W  = 2;
  localparam int FWD_CNT_W  = 16;

  // Select encodings driven by the hazard unit onto sel
  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_SEL_REG   = 2'd0,
    FWD_SEL_EXMEM = 2'd1,
    FWD_SEL_MEMWB = 2'd2
  } fwd_sel_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fwd_operand_mux_reg_sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == {CNT_W{1'b1}});

  // Count register, held at its ceiling instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && !w_at_max) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/fwd_operand_mux_reg.sv
// Registered NUM_IN:1 operand/forwarding mux with stall/flush, a sticky
// illegal-select flag and per-input saturating selection counters.
module fwd_operand_mux_reg
  import fwd_pkg::*;
#(
  parameter int WIDTH  = FWD_WIDTH,
  parameter int NUM_IN = FWD_NUM_IN,
  parameter int SEL_W  = FWD_SEL_W,
  parameter int CNT_W  = FWD_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    sel_err,
  input  logic                    err_clr,
  input  logic [SEL_W-1:0]        cnt_idx,
  output logic [CNT_W-1:0]        cnt_val
);

  if ((NUM_IN < 2) || (NUM_IN > 16) || (clog2(NUM_IN) > SEL_W)) begin : g_param_check
    $error("fwd_operand_mux_reg: illegal parameters NUM_IN=%0d SEL_W=%0d", NUM_IN, SEL_W);
  end

  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_sel_err;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_legal;
  logic             w_accept;
  logic [CNT_W-1:0] w_cnt [NUM_IN];
  logic [CNT_W-1:0] w_cnt_val;

  assign w_sel_legal = ({1'b0, sel} < NUM_IN_W);
  assign w_accept    = in_valid && !stall && !flush;

  // Source selection; an out-of-range select matches no input and yields zero
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        w_sel_data = in_data[k*WIDTH +: WIDTH];
      end else begin
        w_sel_data = w_sel_data;
      end
    end
  end

  // Pipeline register: flush beats stall; bubbles leave the data untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (stall) begin
      r_data  <= r_data;
      r_valid <= r_valid;
    end else if (in_valid) begin
      r_data  <= w_sel_data;
      r_valid <= 1'b1;
    end else begin
      r_data  <= r_data;
      r_valid <= 1'b0;
    end
  end

  // Sticky illegal-select flag; a new error outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_err <= 1'b0;
    end else if (w_accept && !w_sel_legal) begin
      r_sel_err <= 1'b1;
    end else if (err_clr) begin
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= r_sel_err;
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_cnt
    sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_accept && (sel == SEL_W'(g))),
      .count (w_cnt[g])
    );
  end

  // Counter readback; indices with no counter read as zero
  always_comb begin
    w_cnt_val = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (cnt_idx == SEL_W'(k)) begin
        w_cnt_val = w_cnt[k];
      end else begin
        w_cnt_val = w_cnt_val;
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign sel_err   = r_sel_err;
  assign cnt_val   = w_cnt_val;

endmodule

// File: tb/tb_fwd_operand_mux_reg.sv
// Self-checking bench: three configurations (default, 4-bit counters,
// 8-bit x 5 inputs) checked against a cycle-level behavioural model.
module tb_fwd_operand_mux_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  d_rst, d_stall, d_flush, d_valid, d_clr;
  logic [2:0]  d_sel [3];
  logic [2:0]  d_idx [3];
  logic [31:0] d_in  [3][5];

  logic [95:0] w_in0, w_in1;
  logic [39:0] w_in2;
  logic [31:0] o_data0, o_data1;
  logic [7:0]  o_data2;
  logic [2:0]  o_valid, o_err;
  logic [15:0] o_cnt0, o_cnt2;
  logic [3:0]  o_cnt1;

  assign w_in0 = {d_in[0][2], d_in[0][1], d_in[0][0]};
  assign w_in1 = {d_in[1][2], d_in[1][1], d_in[1][0]};
  assign w_in2 = {d_in[2][4][7:0], d_in[2][3][7:0], d_in[2][2][7:0], d_in[2][1][7:0], d_in[2][0][7:0]};

  fwd_operand_mux_reg dut0 (
    .clk(clk), .rst(d_rst[0]), .in_data(w_in0), .sel(d_sel[0][1:0]), .in_valid(d_valid[0]),
    .stall(d_stall[0]), .flush(d_flush[0]), .out_data(o_data0), .out_valid(o_valid[0]),
    .sel_err(o_err[0]), .err_clr(d_clr[0]), .cnt_idx(d_idx[0][1:0]), .cnt_val(o_cnt0));

  fwd_operand_mux_reg #(.CNT_W(4)) dut1 (
    .clk(clk), .rst(d_rst[1]), .in_data(w_in1), .sel(d_sel[1][1:0]), .in_valid(d_valid[1]),
    .stall(d_stall[1]), .flush(d_flush[1]), .out_data(o_data1), .out_valid(o_valid[1]),
    .sel_err(o_err[1]), .err_clr(d_clr[1]), .cnt_idx(d_idx[1][1:0]), .cnt_val(o_cnt1));

  fwd_operand_mux_reg #(.WIDTH(8), .NUM_IN(5), .SEL_W(3)) dut2 (
    .clk(clk), .rst(d_rst[2]), .in_data(w_in2), .sel(d_sel[2]), .in_valid(d_valid[2]),
    .stall(d_stall[2]), .flush(d_flush[2]), .out_data(o_data2), .out_valid(o_valid[2]),
    .sel_err(o_err[2]), .err_clr(d_clr[2]), .cnt_idx(d_idx[2]), .cnt_val(o_cnt2));

  // Reference model state per configuration
  logic [31:0] m_data  [3];
  bit          m_valid [3];
  bit          m_err   [3];
  int unsigned m_cnt   [3][16];
  int          n_in  [3] = '{3, 3, 5};
  int unsigned cmax  [3] = '{65535, 15, 65535};
  logic [31:0] dmask [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h000000FF};
  int          smax  [3] = '{3, 3, 7};

  int          checks = 0;
  int          errors = 0;
  bit          hold_in = 1'b0;
  logic [15:0] obs_cnt, exp_cnt;
  logic [31:0] pat [3] = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC};

  function automatic logic [33:0] q_out(input int d);
    case (d)
      0:       return {o_data0, o_valid[0], o_err[0]};
      1:       return {o_data1, o_valid[1], o_err[1]};
      default: return {24'd0, o_data2, o_valid[2], o_err[2]};
    endcase
  endfunction

  function automatic logic [15:0] q_cnt(input int d);
    case (d)
      0:       return o_cnt0;
      1:       return {12'd0, o_cnt1};
      default: return o_cnt2;
    endcase
  endfunction

  function automatic logic [33:0] m_out(input int d);
    return {m_data[d], m_valid[d], m_err[d]};
  endfunction

  // One clock of stimulus on configuration d (others stalled), model advanced alongside
  task automatic step(input int d, input bit r, input bit fl, input bit st, input bit iv,
                      input bit ec, input int s, input int idx);
    bit acc;
    @(negedge clk);
    for (int e = 0; e < 3; e++) begin
      d_rst[e] = 1'b0; d_stall[e] = 1'b1; d_flush[e] = 1'b0; d_valid[e] = 1'b0; d_clr[e] = 1'b0;
    end
    d_rst[d] = r; d_flush[d] = fl; d_stall[d] = st; d_valid[d] = iv; d_clr[d] = ec;
    d_sel[d] = 3'(s); d_idx[d] = 3'(idx);
    if (!hold_in) begin
      for (int k = 0; k < 5; k++) d_in[d][k] = $urandom;
    end
    #1;
    obs_cnt = q_cnt(d);
    exp_cnt = (idx < n_in[d]) ? 16'(m_cnt[d][idx]) : 16'd0;
    acc = !r && !fl && !st && iv;
    if (r) begin
      m_data[d] = 32'd0; m_valid[d] = 1'b0; m_err[d] = 1'b0;
      for (int k = 0; k < 16; k++) m_cnt[d][k] = 0;
    end else begin
      if (acc && s >= n_in[d]) m_err[d] = 1'b1;
      else if (ec) m_err[d] = 1'b0;
      if (fl) begin
        m_data[d] = 32'd0; m_valid[d] = 1'b0;
      end else if (!st) begin
        m_valid[d] = iv;
        if (iv) begin
          if (s < n_in[d]) begin
            m_data[d] = d_in[d][s] & dmask[d];
            if (m_cnt[d][s] < cmax[d]) m_cnt[d][s] = m_cnt[d][s] + 1;
          end else begin
            m_data[d] = 32'd0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      step(d, 1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (q_out(d) !== 34'd0) begin
        errors++; $display("FAIL reset_out dut%0d: got %h want 0", d, q_out(d));
      end
      for (int i = 0; i <= smax[d]; i++) begin
        step(d, 0, 0, 1, 0, 0, 0, i);
        checks++;
        if (obs_cnt !== 16'd0) begin
          errors++; $display("FAIL reset_cnt dut%0d idx%0d: got %0d want 0", d, i, obs_cnt);
        end
      end
    end
  endtask

  task automatic test_legal();
    hold_in = 1'b1;
    for (int k = 0; k < 3; k++) d_in[0][k] = pat[k];
    for (int s = 0; s < 3; s++) begin
      step(0, 0, 0, 0, 1, 0, s, s);
      checks++;
      if (q_out(0) !== {pat[s], 1'b1, 1'b0} || q_out(0) !== m_out(0)) begin
        errors++; $display("FAIL legal_out sel%0d: got %h want %h", s, q_out(0), m_out(0));
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0, 0, 0, i);
      checks++;
      if (obs_cnt !== exp_cnt || obs_cnt !== 16'd1) begin
        errors++; $display("FAIL legal_cnt idx%0d: got %0d want %0d", i, obs_cnt, exp_cnt);
      end
    end
    hold_in = 1'b0;
  endtask

  task automatic test_illegal();
    step(0, 0, 0, 0, 1, 0, 3, 0);
    checks++;
    if (q_out(0) !== {32'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL illegal_set: got %h want %h", q_out(0), {32'd0, 1'b1, 1'b1});
    end
    step(0, 0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (o_err[0] !== 1'b0 || q_out(0) !== m_out(0)) begin
      errors++; $display("FAIL illegal_clear: got %h want %h", q_out(0), m_out(0));
    end
    step(0, 0, 0, 0, 1, 1, 3, 0);
    checks++;
    if (o_err[0] !== 1'b1 || q_out(0) !== m_out(0)) begin
      errors++; $display("FAIL illegal_set_wins: got %h want %h", q_out(0), m_out(0));
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0, 0, 0, i);
      checks++;
      if (obs_cnt !== exp_cnt) begin
        errors++; $display("FAIL illegal_cnt idx%0d: got %0d want %0d", i, obs_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_stall_flush();
    hold_in = 1'b1;
    for (int k = 0; k < 3; k++) d_in[0][k] = pat[k];
    step(0, 0, 0, 0, 1, 0, 1, 2);
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 1, 1, 0, 2, 2);
      checks++;
      if (o_data0 !== 32'hBBBBBBBB || q_out(0) !== m_out(0)) begin
        errors++; $display("FAIL stall_hold c%0d: got %h want %h", c, q_out(0), m_out(0));
      end
      checks++;
      if (obs_cnt !== exp_cnt) begin
        errors++; $display("FAIL stall_cnt c%0d: got %0d want %0d", c, obs_cnt, exp_cnt);
      end
    end
    step(0, 0, 1, 1, 1, 0, 2, 2);
    checks++;
    if (o_data0 !== 32'd0 || o_valid[0] !== 1'b0 || q_out(0) !== m_out(0)) begin
      errors++; $display("FAIL flush_over_stall: got %h want %h", q_out(0), m_out(0));
    end
    step(0, 0, 0, 1, 0, 0, 0, 2);
    checks++;
    if (obs_cnt !== exp_cnt) begin
      errors++; $display("FAIL flush_cnt: got %0d want %0d", obs_cnt, exp_cnt);
    end
    hold_in = 1'b0;
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 20; c++) begin
      step(1, 0, 0, 0, 1, 0, 1, 1);
      checks++;
      if (obs_cnt !== exp_cnt || q_out(1) !== m_out(1)) begin
        errors++; $display("FAIL sat_run c%0d: got %0d/%h want %0d/%h", c, obs_cnt, q_out(1), exp_cnt, m_out(1));
      end
    end
    step(1, 0, 0, 1, 0, 0, 0, 1);
    checks++;
    if (obs_cnt !== 16'd15) begin
      errors++; $display("FAIL sat_hold: got %0d want 15", obs_cnt);
    end
    step(1, 0, 0, 1, 0, 0, 0, 3);
    checks++;
    if (obs_cnt !== 16'd0) begin
      errors++; $display("FAIL sat_idx3: got %0d want 0", obs_cnt);
    end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 0, 0, 1, 0, 3, 0);
    step(0, 0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0, 2, 0);
    step(0, 1, 0, 1, 1, 0, 2, 0);
    checks++;
    if (q_out(0) !== 34'd0) begin
      errors++; $display("FAIL rstmid_out: got %h want 0", q_out(0));
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0, 0, 0, i);
      checks++;
      if (obs_cnt !== 16'd0) begin
        errors++; $display("FAIL rstmid_cnt idx%0d: got %0d want 0", i, obs_cnt);
      end
    end
    test_legal();
  endtask

  task automatic test_general();
    hold_in = 1'b1;
    for (int k = 0; k < 5; k++) d_in[2][k] = 32'((k + 1) * 17);
    step(2, 0, 0, 0, 1, 0, 4, 4);
    checks++;
    if (o_data2 !== 8'h55 || q_out(2) !== m_out(2)) begin
      errors++; $display("FAIL gen_sel4: got %h want %h", q_out(2), m_out(2));
    end
    for (int s = 5; s < 8; s++) begin
      step(2, 0, 0, 0, 0, 1, 0, 4);
      step(2, 0, 0, 0, 1, 0, s, s);
      checks++;
      if (q_out(2) !== {32'd0, 1'b1, 1'b1}) begin
        errors++; $display("FAIL gen_illegal sel%0d: got %h want %h", s, q_out(2), {32'd0, 1'b1, 1'b1});
      end
    end
    hold_in = 1'b0;
  endtask

  task automatic test_random();
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 300; c++) begin
        step(d, ($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 5) == 0), $urandom_range(0, smax[d]), $urandom_range(0, smax[d]));
        checks++;
        if (q_out(d) !== m_out(d)) begin
          errors++; $display("FAIL rand_out dut%0d c%0d: got %h want %h", d, c, q_out(d), m_out(d));
        end
        checks++;
        if (obs_cnt !== exp_cnt) begin
          errors++; $display("FAIL rand_cnt dut%0d c%0d: got %0d want %0d", d, c, obs_cnt, exp_cnt);
        end
      end
    end
  endtask

  initial begin
    for (int e = 0; e < 3; e++) begin
      d_sel[e] = 3'd0; d_idx[e] = 3'd0;
      for (int k = 0; k < 5; k++) d_in[e][k] = 32'd0;
    end
    d_rst = 3'b111; d_stall = 3'b000; d_flush = 3'b000; d_valid = 3'b000; d_clr = 3'b000;
    test_reset();
    test_legal();
    test_illegal();
    test_stall_flush();
    test_saturation();
    test_reset_mid();
    test_general();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
